// File: rtl/ni_req_flit_tx.sv
// NI request packetizer: captures one write request and serializes it as
// head, address/data body and checksum tail flits on a valid/ready link.
module ni_req_flit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_dest,
  input  logic [3:0]            req_src,
  input  logic [2:0]            req_mode,
  input  logic [1:0]            req_flags,
  output logic [15:0]           flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_last,
  output logic                  busy
);

  localparam int NUM_DATA_FLITS = (DATA_WIDTH + 14) / 15;
  localparam int NUM_BODY_FLITS = NUM_DATA_FLITS + 1;
  localparam int TOTAL_FLITS    = NUM_BODY_FLITS + 2;
  localparam int PAD_W          = NUM_DATA_FLITS * 15;
  localparam int CNT_W          = (NUM_BODY_FLITS > 1) ? $clog2(NUM_BODY_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BODY = CNT_W'(NUM_BODY_FLITS - 1);

  generate
    if (ADDR_WIDTH > 15 || TOTAL_FLITS > 7) begin : g_param_check
      $error("ni_req_flit_tx: address must fit one body flit and packet length must fit 3 bits");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            dest_q, src_q;
  logic [2:0]            mode_q;
  logic [1:0]            flags_q;
  logic                  load;

  logic [PAD_W-1:0]      data_pad;
  logic [14:0]           body_bits [NUM_BODY_FLITS];
  logic [14:0]           csum;

  assign data_pad = PAD_W'(data_q);

  // Data flits first (zero-padded past DATA_WIDTH), address flit last.
  always_comb begin
    for (int unsigned k = 0; k < NUM_DATA_FLITS; k++) begin
      body_bits[k] = data_pad[15*k +: 15];
    end
    body_bits[NUM_BODY_FLITS-1] = 15'(addr_q);
  end

  always_comb begin
    csum = '0;
    for (int unsigned k = 0; k < NUM_BODY_FLITS; k++) begin
      csum = csum ^ body_bits[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (flit_ready) state_d = BODY;
      end
      BODY: begin
        if (flit_ready) begin
          if (cnt_q == LAST_BODY) begin
            cnt_d   = '0;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TAIL: begin
        // Accepting here chains the next packet with no idle bubble.
        req_ready = flit_ready;
        if (flit_ready) begin
          if (req_valid) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = HEAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flit_out = '0;
    case (state_q)
      HEAD:    flit_out = {3'(TOTAL_FLITS), flags_q, mode_q, dest_q, src_q};
      BODY:    flit_out = {body_bits[cnt_q], 1'b0};
      TAIL:    flit_out = {csum, 1'b1};
      default: flit_out = '0;
    endcase
  end

  assign flit_valid = (state_q != IDLE);
  assign flit_last  = (state_q == TAIL);
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      mode_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        data_q  <= req_data;
        addr_q  <= req_addr;
        dest_q  <= req_dest;
        src_q   <= req_src;
        mode_q  <= req_mode;
        flags_q <= req_flags;
      end
    end
  end

endmodule

// File: tb/tb_ni_req_flit_tx.sv
// Bench for ni_req_flit_tx: directed scenarios plus randomized traffic
// checked against a flit-queue reference model built at request handshake.
module tb_ni_req_flit_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [13:0] req_addr = '0;
  logic [3:0]  req_dest = '0;
  logic [3:0]  req_src = '0;
  logic [2:0]  req_mode = '0;
  logic [1:0]  req_flags = '0;
  logic [15:0] flit_out;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic        flit_last;
  logic        busy;

  ni_req_flit_tx #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_addr(req_addr), .req_dest(req_dest),
    .req_src(req_src), .req_mode(req_mode), .req_flags(req_flags),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_last(flit_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q[$];   // {last, flit}
  logic [15:0] obs[$];
  logic        stall_prev = 1'b0;
  logic [15:0] prev_flit = '0;

  logic [15:0] gold1 [6] = '{16'hD15A, 16'h7DDE, 16'h7AB6, 16'h0006, 16'h2468, 16'h2307};
  logic [15:0] gold2 [6] = '{16'hD15A, 16'hFFFE, 16'hFFFE, 16'h0006, 16'h7FFE, 16'h7FF9};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_pkt(input logic [31:0] d, input logic [13:0] a,
                                   input logic [3:0] dst, input logic [3:0] src,
                                   input logic [2:0] m, input logic [1:0] fl);
    logic [14:0] bb [4];
    logic [14:0] cs;
    cs = '0;
    for (int k = 0; k < 3; k++) bb[k] = 15'((d >> (15 * k)) & 32'h7FFF);
    bb[3] = 15'(a);
    exp_q.push_back({1'b0, 3'd6, fl, m, dst, src});
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, bb[k], 1'b0});
      cs = cs ^ bb[k];
    end
    exp_q.push_back({1'b1, cs, 1'b1});
  endfunction

  // Called at the negedge: inputs are stable for the coming rising edge.
  task automatic sample();
    logic exp_valid, exp_rr;
    if (!rst_n) return;
    exp_valid = (exp_q.size() != 0);
    exp_rr    = (exp_q.size() == 0) || (exp_q.size() == 1 && flit_ready);
    chk("flit_valid", {31'b0, flit_valid}, {31'b0, exp_valid});
    chk("busy", {31'b0, busy}, {31'b0, exp_valid});
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rr});
    if (stall_prev) chk("hold_flit", {16'b0, flit_out}, {16'b0, prev_flit});
    if (exp_valid) begin
      chk("flit_out", {16'b0, flit_out}, {16'b0, exp_q[0][15:0]});
      chk("flit_last", {31'b0, flit_last}, {31'b0, exp_q[0][16]});
    end else begin
      chk("idle_flit", {15'b0, flit_last, flit_out}, 32'h0);
    end
    if (flit_valid && flit_ready) begin
      obs.push_back(flit_out);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (req_valid && req_ready)
      push_pkt(req_data, req_addr, req_dest, req_src, req_mode, req_flags);
    stall_prev = flit_valid && !flit_ready;
    prev_flit  = flit_out;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b = 0;
    while (obs.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk("wait_budget", obs.size(), n);
  endtask

  task automatic set_req1();
    req_data = 32'hDEADBEEF; req_addr = 14'h1234; req_dest = 4'h5;
    req_src = 4'hA; req_mode = 3'b001; req_flags = 2'b10;
  endtask

  task automatic cmp_gold(input string tag, input int base, input logic [15:0] g [6]);
    for (int i = 0; i < 6; i++) chk(tag, {16'b0, obs[base + i]}, {16'b0, g[i]});
  endtask

  initial begin
    #1;
    chk("rst_outputs", {14'b0, busy, flit_valid, flit_last, flit_out}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // Single packet; inputs scrambled right after the handshake
    obs.delete();
    set_req1(); req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_data = '0; req_addr = '0;
    wait_obs(6, 30);
    if (obs.size() >= 6) cmp_gold("single", 0, gold1);
    repeat (2) tick();

    // Backpressure during body 1
    obs.delete();
    set_req1(); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_obs(2, 20);
    flit_ready = 1'b0;
    repeat (3) tick();
    flit_ready = 1'b1;
    wait_obs(6, 30);
    if (obs.size() >= 6) cmp_gold("backpressure", 0, gold1);
    repeat (2) tick();

    // Back-to-back: second request held until the tail cycle
    obs.delete();
    set_req1(); req_valid = 1'b1;
    tick();
    req_data = 32'hFFFFFFFF; req_addr = 14'h3FFF;
    begin
      int b = 0;
      while (obs.size() < 6 && b < 30) begin tick(); b++; end
    end
    req_valid = 1'b0;
    wait_obs(12, 40);
    if (obs.size() >= 12) begin
      cmp_gold("b2b_first", 0, gold1);
      cmp_gold("b2b_second", 6, gold2);
    end
    repeat (2) tick();

    // Reset while body 2 is on the link
    obs.delete();
    set_req1(); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_obs(3, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {14'b0, busy, flit_valid, flit_last, flit_out}, 32'h0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    obs.delete();
    set_req1(); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_obs(6, 30);
    if (obs.size() >= 6) cmp_gold("after_rst", 0, gold1);

    // Idle
    repeat (10) tick();
    chk("idle_state", {29'b0, flit_valid, busy, req_ready}, 32'h1);

    // Randomized traffic with random backpressure and changing inputs
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      flit_ready = ($urandom_range(0, 3) != 0);
      req_data   = $urandom;
      req_addr   = 14'($urandom);
      req_dest   = 4'($urandom);
      req_src    = 4'($urandom);
      req_mode   = 3'($urandom);
      req_flags  = 2'($urandom);
      tick();
    end
    req_valid = 1'b0;
    flit_ready = 1'b1;
    begin
      int b = 0;
      while (exp_q.size() != 0 && b < 20) begin tick(); b++; end
    end
    chk("drain_empty", exp_q.size(), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
